misc_exec_unit_buffered: RTL and testbench

// Next-generation misc execution element for the core's exec stage.

---
 rtl/misc_exec_unit_buffered_if.sv | 31 +++
 rtl/misc_exec_unit_buffered.sv | 184 ++++++++++++++++++
 tb/tb_misc_exec_unit_buffered.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/misc_exec_unit_buffered_if.sv
// Exec-stage handshake plus UART TX/RX signals for the misc execution unit.
// The master drives start/operands/UART responses; the slave is the unit itself.
interface misc_exec_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [31:0]           pc;
    logic [5:0]            inst_num;
    logic [DATA_WIDTH-1:0] rs;
    logic [DATA_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] out;
    logic                  completed;
    logic                  halted;
    logic                  tx_empty;
    logic [7:0]            uart_in_data;
    logic                  uart_in_valid;
    logic                  uart_in_ready;
    logic                  uart_out_valid;
    logic [7:0]            uart_out_data;
    logic                  uart_out_ready;

    modport master (
        output start, pc, inst_num, rs, rd, uart_in_ready, uart_out_data, uart_out_ready,
        input  out, completed, halted, tx_empty, uart_in_data, uart_in_valid, uart_out_valid
    );

    modport slave (
        input  start, pc, inst_num, rs, rd, uart_in_ready, uart_out_data, uart_out_ready,
        output out, completed, halted, tx_empty, uart_in_data, uart_in_valid, uart_out_valid
    );
endinterface

// File: rtl/misc_exec_unit_buffered.sv
// Misc exec element: NOP/HALT/IN/INW/OUT/OUTW/FLUSH with a byte TX FIFO drained independently.
// NOP/OUT(with space)/FLUSH(empty) retire one edge after start; OUT stalls only while the FIFO is full.
module misc_exec_unit_buffered #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    misc_exec_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CW    = $clog2(BYTES + 1);

    typedef enum logic [2:0] {S_IDLE, S_RX, S_TX_PUSH, S_DRAIN, S_DONE, S_HALT} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    // data_q is the TX shift register during OUT/OUTW and the RX assembly buffer during IN/INW
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]         rem_q, rem_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  completed_q, completed_d;
    logic                  halted_q, halted_d;
    logic                  rx_vld_q, rx_vld_d;
    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [7:0]            mem_d [FIFO_DEPTH];
    logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d;

    logic                  full, empty, pop, push, accept, tx_go;
    logic [7:0]            push_byte;
    logic [DATA_WIDTH-1:0] tx_src, rx_asm;
    logic [CW-1:0]         tx_rem;
    logic                  unused_pc;

    assign unused_pc = ^bus.pc;
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty  = (wptr_q == rptr_q);
    assign pop    = !empty && bus.uart_in_ready;
    assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        data_d      = data_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        completed_d = completed_q;
        halted_d    = halted_q;
        rx_vld_d    = rx_vld_q;
        push        = 1'b0;
        push_byte   = 8'h00;
        tx_go       = 1'b0;
        tx_src      = data_q;
        tx_rem      = rem_q;
        rx_asm      = data_q;
        for (int b = 0; b < BYTES; b++) begin
            if (idx_q == IW'(b)) rx_asm[b*8 +: 8] = bus.uart_out_data;
        end

        if (accept) begin
            completed_d = 1'b0;
            case (bus.inst_num)
                6'd5: begin
                    out_d    = '1;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end
                6'd6, 6'd8: begin
                    state_d  = S_RX;
                    rx_vld_d = 1'b1;
                    data_d   = (bus.inst_num == 6'd6) ? bus.rd : '0;
                    rem_d    = (bus.inst_num == 6'd6) ? CW'(1) : CW'(BYTES);
                    idx_d    = '0;
                end
                6'd7, 6'd9: begin
                    tx_go  = 1'b1;
                    tx_src = bus.rs;
                    tx_rem = (bus.inst_num == 6'd7) ? CW'(1) : CW'(BYTES);
                end
                6'd10: begin
                    if (empty) begin
                        completed_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: begin
                    completed_d = 1'b1;
                    state_d     = S_DONE;
                end
            endcase
        end else begin
            case (state_q)
                S_RX: begin
                    if (rx_vld_q && bus.uart_out_ready) begin
                        rx_vld_d = 1'b0;
                        data_d   = rx_asm;
                        idx_d    = idx_q + IW'(1);
                        rem_d    = rem_q - CW'(1);
                        if (rem_q == CW'(1)) begin
                            out_d       = rx_asm;
                            completed_d = 1'b1;
                            state_d     = S_DONE;
                        end
                    end else if (!rx_vld_q) begin
                        rx_vld_d = 1'b1;
                    end
                end
                S_TX_PUSH: tx_go = 1'b1;
                S_DRAIN: begin
                    if (empty) begin
                        completed_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
                default: ;
            endcase
        end

        // Space is judged on the registered pointers, so a same-cycle pop never frees a slot.
        if (tx_go) begin
            if (!full) begin
                push      = 1'b1;
                push_byte = tx_src[7:0];
                data_d    = tx_src >> 8;
                rem_d     = tx_rem - CW'(1);
                if (tx_rem == CW'(1)) begin
                    completed_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_TX_PUSH;
                end
            end else begin
                data_d  = tx_src;
                rem_d   = tx_rem;
                state_d = S_TX_PUSH;
            end
        end

        mem_d = mem_q;
        if (push) mem_d[wptr_q[AW-1:0]] = push_byte;
        wptr_d = wptr_q + {{AW{1'b0}}, push};
        rptr_d = rptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_q       <= '0;
            data_q      <= '0;
            rem_q       <= '0;
            idx_q       <= '0;
            completed_q <= 1'b0;
            halted_q    <= 1'b0;
            rx_vld_q    <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            completed_q <= completed_d;
            halted_q    <= halted_d;
            rx_vld_q    <= rx_vld_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_q       <= mem_d;
        end
    end

    assign bus.out            = out_q;
    assign bus.completed      = completed_q;
    assign bus.halted         = halted_q;
    assign bus.tx_empty       = empty;
    assign bus.uart_in_valid  = !empty;
    assign bus.uart_in_data   = mem_q[rptr_q[AW-1:0]];
    assign bus.uart_out_valid = rx_vld_q;
endmodule

// File: tb/tb_misc_exec_unit_buffered.sv
// Directed timing checks followed by random instruction streams against a byte-queue reference model.
module tb_misc_exec_unit_buffered;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   auto_uart = 1'b0;
    logic [7:0]  tx_exp [$];
    logic [7:0]  rx_bytes [$];
    logic [31:0] out_m;

    always #5 clk = ~clk;

    misc_exec_if #(.DATA_WIDTH(32)) bus ();

    misc_exec_unit_buffered #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        logic [7:0] b;
        @(posedge clk);
        #1;
        if (auto_uart) begin
            bus.uart_in_ready  = 1'($urandom_range(0, 1));
            bus.uart_out_ready = 1'b0;
            if (bus.uart_out_valid && $urandom_range(0, 2) == 0) begin
                b = 8'($urandom);
                bus.uart_out_data  = b;
                bus.uart_out_ready = 1'b1;
                rx_bytes.push_back(b);
            end
        end
    endtask

    // Issue one instruction for a single cycle and record the bytes it must emit.
    task automatic issue(input logic [5:0] inst, input logic [31:0] rs, input logic [31:0] rd);
        bus.start = 1'b1;
        bus.inst_num = inst;
        bus.rs = rs;
        bus.rd = rd;
        if (inst == 6'd7) tx_exp.push_back(rs[7:0]);
        if (inst == 6'd9) for (int k = 0; k < 4; k++) tx_exp.push_back(8'(rs >> (8 * k)));
        step();
        bus.start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.uart_in_valid && bus.uart_in_ready) begin
            if (tx_exp.size() == 0) chk("tx_unexpected", 1, 0);
            else chk("tx_byte", bus.uart_in_data, tx_exp.pop_front());
        end
    end

    initial begin
        int n;
        int sel;
        logic [5:0]  inst;
        logic [31:0] rs, rd, w;
        bus.start = 0; bus.pc = 0; bus.inst_num = 0; bus.rs = 0; bus.rd = 0;
        bus.uart_in_ready = 0; bus.uart_out_data = 0; bus.uart_out_ready = 0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_completed", bus.completed, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_rx_valid", bus.uart_out_valid, 0);
        chk("rst_tx_empty", bus.tx_empty, 1);
        chk("rst_tx_valid", bus.uart_in_valid, 0);

        issue(6'd4, 32'h0, 32'h0);
        chk("nop_completed", bus.completed, 1);
        chk("nop_out", bus.out, 0);
        chk("nop_tx_empty", bus.tx_empty, 1);

        issue(6'd7, 32'h0000_0041, 32'h0);
        chk("out_completed", bus.completed, 1);
        chk("out_tx_valid", bus.uart_in_valid, 1);
        step();
        chk("out_data_held", bus.uart_in_data, 8'h41);
        bus.uart_in_ready = 1'b1;
        step();
        bus.uart_in_ready = 1'b0;
        chk("out_drained", bus.tx_empty, 1);

        issue(6'd9, 32'h4433_2211, 32'h0);
        for (int e = 2; e <= 4; e++) begin
            chk("outw_not_done", bus.completed, 0);
            step();
        end
        chk("outw_done_t4", bus.completed, 1);
        issue(6'd7, 32'h0000_0055, 32'h0);
        chk("out_full_stall", bus.completed, 0);
        step();
        chk("out_full_stall2", bus.completed, 0);
        bus.uart_in_ready = 1'b1;
        step();
        bus.uart_in_ready = 1'b0;
        chk("out_no_same_cycle_push", bus.completed, 0);
        step();
        chk("out_after_pop", bus.completed, 1);
        bus.uart_in_ready = 1'b1;
        repeat (5) step();
        bus.uart_in_ready = 1'b0;
        chk("outw_order_drained", tx_exp.size(), 0);
        chk("outw_tx_empty", bus.tx_empty, 1);

        issue(6'd6, 32'h0, 32'hAABB_CCDD);
        chk("in_req", bus.uart_out_valid, 1);
        step(); step();
        chk("in_req_held", bus.uart_out_valid, 1);
        bus.uart_out_ready = 1'b1;
        bus.uart_out_data = 8'h5A;
        step();
        bus.uart_out_ready = 1'b0;
        chk("in_completed", bus.completed, 1);
        chk("in_out", bus.out, 32'hAABB_CC5A);
        chk("in_req_drop", bus.uart_out_valid, 0);

        issue(6'd8, 32'h0, 32'h1234_5678);
        for (int k = 1; k <= 4; k++) begin
            n = 0;
            while (!bus.uart_out_valid && n < 20) begin step(); n++; end
            if (n >= 20) chk("inw_req_timeout", 1, 0);
            bus.uart_out_ready = 1'b1;
            bus.uart_out_data = 8'(k);
            step();
            bus.uart_out_ready = 1'b0;
            if (k < 4) chk("inw_not_done", bus.completed, 0);
        end
        chk("inw_completed", bus.completed, 1);
        chk("inw_out", bus.out, 32'h0403_0201);

        issue(6'd7, 32'hA1, 0); issue(6'd7, 32'hA2, 0); issue(6'd7, 32'hA3, 0);
        bus.uart_in_ready = 1'b1;
        issue(6'd10, 0, 0);
        chk("flush_pop1", bus.completed, 0);
        step();
        chk("flush_pop2", bus.completed, 0);
        step();
        chk("flush_pop3", bus.completed, 0);
        step();
        chk("flush_done", bus.completed, 1);
        chk("flush_empty", bus.tx_empty, 1);
        bus.uart_in_ready = 1'b0;
        issue(6'd10, 0, 0);
        chk("flush_empty_t1", bus.completed, 1);

        issue(6'd7, 32'h77, 0);
        issue(6'd5, 0, 0);
        chk("halt_out", bus.out, 32'hFFFF_FFFF);
        chk("halt_halted", bus.halted, 1);
        chk("halt_completed", bus.completed, 0);
        issue(6'd4, 0, 0);
        chk("halt_ignores_start", bus.completed, 0);
        bus.uart_in_ready = 1'b1;
        step();
        bus.uart_in_ready = 1'b0;
        chk("halt_drains", bus.tx_empty, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("halt_reset", bus.halted, 0);

        issue(6'd9, 32'hDEAD_BEEF, 0);
        step();
        reset = 1'b1;
        tx_exp.delete();
        step();
        reset = 1'b0;
        chk("rst_mid_empty", bus.tx_empty, 1);
        chk("rst_mid_completed", bus.completed, 0);
        repeat (3) step();
        chk("rst_mid_no_done", bus.completed, 0);

        out_m = 32'h0;
        auto_uart = 1'b1;
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0: inst = 6'd4;
                1: inst = 6'd6;
                2: inst = 6'd7;
                3: inst = 6'd8;
                4: inst = 6'd9;
                5: inst = 6'd10;
                default: inst = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(11, 63));
            endcase
            rs = $urandom;
            rd = $urandom;
            rx_bytes.delete();
            issue(inst, rs, rd);
            n = 0;
            while (!bus.completed && n < 300) begin step(); n++; end
            if (n >= 300) chk("rand_timeout", inst, 6'h3F);
            if (inst == 6'd6) begin
                chk("rand_in_count", rx_bytes.size(), 1);
                if (rx_bytes.size() >= 1) out_m = {rd[31:8], rx_bytes[0]};
            end else if (inst == 6'd8) begin
                chk("rand_inw_count", rx_bytes.size(), 4);
                if (rx_bytes.size() >= 4) begin
                    w = 32'h0;
                    for (int k = 0; k < 4; k++) w[k*8 +: 8] = rx_bytes[k];
                    out_m = w;
                end
            end
            chk("rand_out", bus.out, out_m);
            if (inst == 6'd10) chk("rand_flush_empty", bus.tx_empty, 1);
        end
        auto_uart = 1'b0;
        bus.uart_in_ready = 1'b1;
        repeat (10) step();
        bus.uart_in_ready = 1'b0;
        chk("final_tx_all_seen", tx_exp.size(), 0);
        chk("final_tx_empty", bus.tx_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
